// File: rtl/sha1_padder_if.sv
// sha1_padder_if: message word stream in, 512-bit padded blocks and core handshake out; slave=padder, master=its environment
interface sha1_padder_if;
  logic [31:0] s_data;
  logic s_valid;
  logic s_last;
  logic [2:0] s_nbytes;
  logic s_ready;
  logic [511:0] blk_data;
  logic blk_start;
  logic blk_first;
  logic core_busy;
  logic core_done;
  logic msg_done;
  modport slave (
    input s_data, s_valid, s_last, s_nbytes, core_busy, core_done,
    output s_ready, blk_data, blk_start, blk_first, msg_done
  );
  modport master (
    output s_data, s_valid, s_last, s_nbytes, core_busy, core_done,
    input s_ready, blk_data, blk_start, blk_first, msg_done
  );
endinterface

// File: rtl/sha1_padder.sv
// sha1_padder: packs a big-endian 32-bit word stream (bus.s_*) into FIPS 180-4 padded 512-bit blocks (bus.blk_*), paced by the core's busy/done, msg_done on the final digest
module sha1_padder #(
  parameter int LEN_W = 64
) (
  input logic clk,
  input logic rstn,
  sha1_padder_if.slave bus
);
  typedef enum logic [1:0] {FILL, ISSUE, WAIT, PADBLK} state_t;
  state_t st, st_d;
  logic [0:15][31:0] words, words_fill;
  logic [3:0] widx;
  logic [LEN_W-1:0] bitlen, bitlen_d;
  logic first, pad_pend, pad_mark, fin;
  logic acc, done;
  logic [2:0] n;
  logic [4:0] m;
  logic [63:0] len64;
  logic [31:0] word_i;
  assign acc = bus.s_valid && bus.s_ready;
  assign done = st == WAIT && bus.core_done;
  assign n = !bus.s_last || bus.s_nbytes > 3'd4 ? 3'd4 : bus.s_nbytes;
  assign m = {1'b0, widx} + {4'd0, n == 3'd4};
  assign bitlen_d = bitlen + LEN_W'({n, 3'b000});
  assign len64 = 64'(bitlen_d);
  // shifts by 32 yield zero, so n==4 keeps the whole word and places no marker here
  assign word_i = (bus.s_data & ~(32'hffffffff >> {n, 3'b000})) | (32'h80000000 >> {n, 3'b000});
  assign bus.blk_data = words;
  assign bus.blk_first = first;
  always_comb begin
    words_fill = words;
    for (int k = 0; k < 16; k++)
      words_fill[k] = 4'(k) == widx ? word_i : bus.s_last && n == 3'd4 && 5'(k) == m ? 32'h80000000 : words[k];
    if (bus.s_last && m <= 5'd13) begin
      words_fill[14] = len64[63:32];
      words_fill[15] = len64[31:0];
    end
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) st <= FILL;
    else st <= st_d;
  always_comb begin
    st_d = st;
    case (st)
      FILL: st_d = acc && (bus.s_last || widx == 4'd15) ? ISSUE : FILL;
      ISSUE: st_d = bus.core_busy ? ISSUE : WAIT;
      WAIT: st_d = !bus.core_done ? WAIT : pad_pend ? PADBLK : FILL;
      default: st_d = ISSUE;
    endcase
  end
  always_comb begin
    bus.s_ready = rstn && st == FILL;
    bus.blk_start = st == ISSUE && !bus.core_busy;
    bus.msg_done = done && fin;
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      widx <= '0;
      words <= '0;
      bitlen <= '0;
      first <= 1'b1;
      pad_pend <= 1'b0;
      pad_mark <= 1'b0;
      fin <= 1'b0;
    end else if (acc) begin
      widx <= widx + 4'd1;
      words <= words_fill;
      bitlen <= bitlen_d;
      fin <= bus.s_last && m <= 5'd13;
      pad_pend <= bus.s_last && m > 5'd13;
      pad_mark <= m == 5'd16;
    end else if (done) begin
      // a pending pad block rebuilds every word in PADBLK, so clearing is always safe
      first <= fin;
      widx <= '0;
      words <= '0;
      bitlen <= fin ? '0 : bitlen;
    end else if (st == PADBLK) begin
      words <= {pad_mark ? 32'h80000000 : 32'h0, 416'h0, 64'(bitlen)};
      fin <= 1'b1;
      pad_pend <= 1'b0;
    end
endmodule

// File: tb/tb_sha1_padder.sv
// tb_sha1_padder: table, hand-written and random checks of sha1_padder against a byte-level padding model
module tb_sha1_padder;
  typedef struct {
    logic [511:0] data;
    bit first;
    bit fin;
  } exp_t;
  typedef struct {
    logic [2:0] nb;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [31:0] w15;
  } vec_t;
  logic clk, rstn;
  bit auto_core;
  logic a_busy, a_done, m_busy, m_done;
  int tests, fails, done_cnt, exp_done;
  exp_t exp_q[$];
  logic [7:0] msg_q[$];
  vec_t tbl[7];
  sha1_padder_if bus();
  sha1_padder dut (.clk(clk), .rstn(rstn), .bus(bus));
  assign bus.core_busy = auto_core ? a_busy : m_busy;
  assign bus.core_done = auto_core ? a_done : m_done;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(negedge clk) if (bus.msg_done) done_cnt++;
  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send_word(input logic [31:0] d, input logic l, input logic [2:0] nb);
    bit ok = 0;
    bus.s_data = d;
    bus.s_last = l;
    bus.s_nbytes = nb;
    bus.s_valid = 1'b1;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(negedge clk);
      ok = bus.s_ready;
      tick();
    end
    bus.s_valid = 1'b0;
    bus.s_last = 1'b0;
    check("accept", ok, 1);
  endtask
  task automatic model_push();
    logic [7:0] p[$];
    logic [63:0] bits;
    exp_t e;
    int nb;
    p = msg_q;
    bits = 64'(msg_q.size()) * 64'd8;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    for (int b = 7; b >= 0; b--) p.push_back(bits[8*b +: 8]);
    nb = p.size() / 64;
    for (int k = 0; k < nb; k++) begin
      e.data = '0;
      for (int j = 0; j < 64; j++) e.data = {e.data[503:0], p[64*k+j]};
      e.first = k == 0;
      e.fin = k == nb - 1;
      exp_q.push_back(e);
    end
    exp_done++;
  endtask
  task automatic send_msg();
    int n = msg_q.size();
    int nw = n == 0 ? 1 : (n + 3) / 4;
    model_push();
    for (int w = 0; w < nw; w++) begin
      logic [31:0] d;
      logic [2:0] nb;
      repeat ($urandom_range(0, 2)) begin
        bus.s_valid = 1'b0;
        bus.s_last = 1'($urandom);
        bus.s_data = $urandom;
        tick();
      end
      d = $urandom;
      for (int j = 0; j < 4; j++) if (4*w + j < n) d[31-8*j -: 8] = msg_q[4*w+j];
      if (w == nw - 1) nb = n - 4*w == 4 ? 3'($urandom_range(4, 7)) : 3'(n - 4*w);
      else nb = 3'($urandom);
      send_word(d, w == nw - 1, nb);
    end
  endtask
  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 4000 && !ok; i++) begin
      @(negedge clk);
      ok = exp_q.size() == 0 && !a_busy && !a_done && done_cnt == exp_done;
    end
    check("idle", ok, 1);
    tick();
  endtask
  // core wrapper stand-in: checks each issued block against the scoreboard, then digests it after a random delay
  initial begin : core
    exp_t e;
    a_busy = 1'b0;
    a_done = 1'b0;
    forever begin
      @(negedge clk);
      if (auto_core && bus.blk_start) begin
        if (exp_q.size() == 0) begin
          check("spurious_start", 1, 0);
          e.data = '0;
          e.first = 0;
          e.fin = 0;
        end else begin
          e = exp_q.pop_front();
          check("blk_data", bus.blk_data, e.data);
          check("blk_first", bus.blk_first, e.first);
        end
        tick();
        a_busy = 1'b1;
        repeat ($urandom_range(0, 3)) tick();
        a_done = 1'b1;
        @(negedge clk);
        check("msg_done", bus.msg_done, e.fin);
        check("blk_hold", bus.blk_data, e.data);
        tick();
        a_done = 1'b0;
        repeat ($urandom_range(0, 2)) tick();
        a_busy = 1'b0;
      end
    end
  end
  initial begin
    exp_t e;
    int lens[$];
    logic [511:0] abc_blk;
    tbl[0] = '{3'd0, 32'h80000000, 32'h0, 32'h0};
    tbl[1] = '{3'd1, 32'h61800000, 32'h0, 32'h8};
    tbl[2] = '{3'd2, 32'h61628000, 32'h0, 32'h10};
    tbl[3] = '{3'd3, 32'h61626380, 32'h0, 32'h18};
    tbl[4] = '{3'd4, 32'h61626364, 32'h80000000, 32'h20};
    tbl[5] = '{3'd5, 32'h61626364, 32'h80000000, 32'h20};
    tbl[6] = '{3'd7, 32'h61626364, 32'h80000000, 32'h20};
    abc_blk = {32'h61626380, 448'h0, 32'h18};
    tests = 0;
    fails = 0;
    done_cnt = 0;
    exp_done = 0;
    auto_core = 0;
    m_busy = 1'b0;
    m_done = 1'b0;
    rstn = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_last = 1'b0;
    bus.s_data = '0;
    bus.s_nbytes = '0;
    repeat (2) @(negedge clk);
    check("rst_s_ready", bus.s_ready, 0);
    check("rst_blk_start", bus.blk_start, 0);
    check("rst_msg_done", bus.msg_done, 0);
    check("rst_blk_data", bus.blk_data, 0);
    check("rst_blk_first", bus.blk_first, 1);
    tick();
    rstn = 1'b1;
    auto_core = 1;
    for (int i = 0; i < 7; i++) begin
      e.data = {tbl[i].w0, tbl[i].w1, 416'h0, tbl[i].w15};
      e.first = 1;
      e.fin = 1;
      exp_q.push_back(e);
      exp_done++;
      send_word(32'h61626364, 1'b1, tbl[i].nb);
      @(negedge clk);
      check("latency", bus.blk_start, 1);
      wait_idle();
    end
    auto_core = 0;
    m_busy = 1'b1;
    m_done = 1'b1;
    @(negedge clk);
    check("done_ignored", bus.msg_done, 0);
    tick();
    m_done = 1'b0;
    send_word(32'h61626300, 1'b1, 3'd3);
    repeat (4) begin
      @(negedge clk);
      check("bp_start", bus.blk_start, 0);
      check("bp_ready", bus.s_ready, 0);
      tick();
    end
    m_busy = 1'b0;
    @(negedge clk);
    check("bp_release", bus.blk_start, 1);
    check("bp_data", bus.blk_data, abc_blk);
    check("bp_first", bus.blk_first, 1);
    tick();
    m_busy = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("one_shot", bus.blk_start, 0);
      tick();
    end
    m_done = 1'b1;
    exp_done++;
    @(negedge clk);
    check("abc_done", bus.msg_done, 1);
    tick();
    m_done = 1'b0;
    m_busy = 1'b0;
    @(negedge clk);
    check("ready_after", bus.s_ready, 1);
    tick();
    msg_q.delete();
    for (int j = 0; j < 64; j++) msg_q.push_back(8'(j));
    send_msg();
    @(negedge clk);
    check("b64_start1", bus.blk_start, 1);
    e = exp_q.pop_front();
    check("b64_data1", bus.blk_data, e.data);
    check("b64_first1", bus.blk_first, 1);
    tick();
    m_done = 1'b1;
    @(negedge clk);
    check("b64_no_done", bus.msg_done, 0);
    tick();
    m_done = 1'b0;
    @(negedge clk);
    check("gap1", bus.blk_start, 0);
    tick();
    @(negedge clk);
    check("gap2", bus.blk_start, 1);
    e = exp_q.pop_front();
    check("b64_data2", bus.blk_data, {32'h80000000, 448'h0, 32'h200});
    check("b64_first2", bus.blk_first, 0);
    tick();
    m_done = 1'b1;
    @(negedge clk);
    check("b64_done", bus.msg_done, 1);
    tick();
    m_done = 1'b0;
    for (int w = 0; w < 16; w++) send_word($urandom, 1'b0, 3'($urandom));
    @(negedge clk);
    check("mid_start", bus.blk_start, 1);
    tick();
    #2 rstn = 1'b0;
    #1;
    check("mid_rst_ready", bus.s_ready, 0);
    check("mid_rst_start", bus.blk_start, 0);
    check("mid_rst_done", bus.msg_done, 0);
    check("mid_rst_data", bus.blk_data, 0);
    check("mid_rst_first", bus.blk_first, 1);
    tick();
    rstn = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("post_rst_start", bus.blk_start, 0);
      tick();
    end
    auto_core = 1;
    msg_q = '{8'h61, 8'h62, 8'h63};
    send_msg();
    wait_idle();
    lens = '{0, 3, 55, 56, 57, 60, 61, 63, 64, 65, 119, 120, 128};
    for (int i = 0; i < 20; i++) lens.push_back($urandom_range(0, 150));
    for (int i = 0; i < lens.size(); i++) begin
      msg_q.delete();
      for (int j = 0; j < lens[i]; j++) msg_q.push_back(8'($urandom));
      send_msg();
      if ($urandom_range(0, 1) == 1) wait_idle();
    end
    wait_idle();
    check("msg_done_count", 512'(done_cnt), 512'(exp_done));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
